ks_pluck_ctrl: RTL and testbench

Sequencer that drives the Karplus-Strong string core through one complete "pluck":
- mutes the core and loads the delay line with LFSR noise, one sample per noise_pulse;
- programs the tap (sel_nota) and the sample-rate divider;
- unmutes the core for a programmed duration, then mutes it again.

It sits between the Nios-side register block or note scheduler and the string core. It replaces software bit-banging of noise, noise_en and noise_pulse.

---
 rtl/ks_pkg.sv | 30 +++
 rtl/ks_pluck_ctrl_if.sv | 16 +
 rtl/ks_lfsr16.sv | 20 ++
 rtl/ks_pluck_ctrl.sv | 152 +++++++++++++++
 tb/tb_ks_pluck_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ks_pkg.sv
// Shared types and constants for the Karplus-Strong pluck sequencer.
// Holds the FSM state enum, LFSR mask, default line depth and the latched request.
package ks_pkg;

    localparam int          KS_LINE_MAX  = 500;
    localparam int          KS_DUR_W     = 24;
    localparam logic [15:0] KS_LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL_WR,
        ST_PULSE_HI,
        ST_PULSE_LO,
        ST_ARM,
        ST_PLAY
    } ks_state_e;

    typedef struct packed {
        logic [9:0]          sel;
        logic [31:0]         div;
        logic [1:0]          amp;
        logic [KS_DUR_W-1:0] dur;
    } ks_pluck_req_t;

    // One step of the 16-bit right-shifting Galois LFSR.
    function automatic logic [15:0] ks_lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? KS_LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/ks_pluck_ctrl_if.sv
// Pluck request handshake between the note scheduler (master) and the sequencer (slave).
interface ks_pluck_ctrl_if
    import ks_pkg::*;
#(
    parameter int DUR_W = KS_DUR_W
);
    logic             req;
    logic             ready;
    logic [9:0]       sel;
    logic [31:0]      div;
    logic [1:0]       amp;
    logic [DUR_W-1:0] dur;

    modport master (output req, sel, div, amp, dur, input ready);
    modport slave  (input req, sel, div, amp, dur, output ready);
endinterface

// File: rtl/ks_lfsr16.sv
// Noise source: 16-bit Galois LFSR that advances one step per adv cycle.
module ks_lfsr16
    import ks_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adv,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= SEED;
        else if (adv)
            q <= ks_lfsr_step(q);
    end

endmodule

// File: rtl/ks_pluck_ctrl.sv
// Sequences one Karplus-Strong pluck: noise fill, tap/divider setup, timed playback.
// Optional KS_PLUCK_RETRIGGER_EN: accept a new pluck while playing and restart the fill.
module ks_pluck_ctrl
    import ks_pkg::*;
#(
    parameter int          LINE_MAX   = KS_LINE_MAX,
    parameter int          PULSE_HALF = 4,
    parameter int          DUR_W      = KS_DUR_W,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    ks_pluck_ctrl_if.slave    pluck,
    input  logic              stop,
    output logic [15:0]       ks_noise,
    output logic              ks_noise_wr,
    output logic              ks_noise_en,
    output logic              ks_noise_pulse,
    output logic [9:0]        ks_sel_nota,
    output logic [31:0]       ks_div_freq_in,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int          PH_W       = $clog2(PULSE_HALF) + 1;
    localparam logic [10:0] LINE_LIMIT = 11'(LINE_MAX);

`ifdef KS_PLUCK_RETRIGGER_EN
    localparam logic READY_IN_PLAY = 1'b1;
`else
    localparam logic READY_IN_PLAY = 1'b0;
`endif

    ks_state_e        state;
    ks_pluck_req_t    req_q;
    logic [9:0]       sample_left;
    logic [PH_W-1:0]  phase;
    logic [DUR_W-1:0] play_cnt;
    logic [15:0]      lfsr_q;

    logic        accept, start, phase_last, refill, lfsr_adv;
    logic [1:0]  fill_amp;
    logic [15:0] noise_next;

    always_comb begin
        accept     = pluck.req && pluck.ready;
        start      = accept && ({1'b0, pluck.sel} < LINE_LIMIT);
        phase_last = (phase == PH_W'(PULSE_HALF - 1));
        refill     = (state == ST_PULSE_LO) && phase_last && (sample_left != 10'd0);
        lfsr_adv   = start || refill;
        fill_amp   = start ? pluck.amp : req_q.amp;
        // The sample written is the freshly stepped LFSR value.
        noise_next = ks_lfsr_step(lfsr_q) >> fill_amp;
    end

    ks_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (lfsr_adv),
        .q     (lfsr_q)
    );

    assign ks_sel_nota = req_q.sel;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch below sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            req_q          <= '0;
            sample_left    <= '0;
            phase          <= '0;
            play_cnt       <= '0;
            ks_noise       <= '0;
            ks_noise_wr    <= 1'b0;
            ks_noise_en    <= 1'b1;
            ks_noise_pulse <= 1'b0;
            ks_div_freq_in <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            pluck.ready    <= 1'b1;
        end else begin
            ks_noise_wr <= 1'b0;
            done        <= 1'b0;
            err         <= accept && !start;

            if (start) begin
                req_q       <= '{sel: pluck.sel, div: pluck.div, amp: pluck.amp,
                                 dur: KS_DUR_W'(pluck.dur)};
                sample_left <= pluck.sel;
                ks_noise    <= noise_next;
                ks_noise_wr <= 1'b1;
                ks_noise_en <= 1'b1;
                busy        <= 1'b1;
                pluck.ready <= 1'b0;
                state       <= ST_FILL_WR;
            end else begin
                case (state)
                    ST_FILL_WR: begin
                        phase          <= '0;
                        ks_noise_pulse <= 1'b1;
                        state          <= ST_PULSE_HI;
                    end
                    ST_PULSE_HI: begin
                        if (phase_last) begin
                            phase          <= '0;
                            ks_noise_pulse <= 1'b0;
                            state          <= ST_PULSE_LO;
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    ST_PULSE_LO: begin
                        if (!phase_last) begin
                            phase <= phase + PH_W'(1);
                        end else if (sample_left == 10'd0) begin
                            ks_div_freq_in <= req_q.div;
                            state          <= ST_ARM;
                        end else begin
                            sample_left <= sample_left - 10'd1;
                            ks_noise    <= noise_next;
                            ks_noise_wr <= 1'b1;
                            state       <= ST_FILL_WR;
                        end
                    end
                    ST_ARM: begin
                        play_cnt    <= DUR_W'(req_q.dur);
                        ks_noise_en <= 1'b0;
                        pluck.ready <= READY_IN_PLAY;
                        state       <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        // A zero duration never counts down, so only stop ends it.
                        if (stop || play_cnt == DUR_W'(1)) begin
                            ks_noise_en <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            pluck.ready <= 1'b1;
                            state       <= ST_IDLE;
                        end else if (play_cnt != '0) begin
                            play_cnt <= play_cnt - DUR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ks_pluck_ctrl.sv
// Self-checking bench for ks_pluck_ctrl: a timeline model derived from the pluck rules
// is compared against every output on each falling edge, plus directed literal checks.
module tb_ks_pluck_ctrl;

    localparam int PH  = 4;
    localparam int PER = 1 + 2 * PH;
`ifdef KS_PLUCK_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic stop  = 1'b0;

    logic [15:0] ks_noise;
    logic        ks_noise_wr, ks_noise_en, ks_noise_pulse;
    logic [9:0]  ks_sel_nota;
    logic [31:0] ks_div_freq_in;
    logic        busy, done, err;

    ks_pluck_ctrl_if #(.DUR_W(24)) pif ();

    ks_pluck_ctrl #(
        .LINE_MAX   (500),
        .PULSE_HALF (PH),
        .DUR_W      (24),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pluck          (pif.slave),
        .stop           (stop),
        .ks_noise       (ks_noise),
        .ks_noise_wr    (ks_noise_wr),
        .ks_noise_en    (ks_noise_en),
        .ks_noise_pulse (ks_noise_pulse),
        .ks_sel_nota    (ks_sel_nota),
        .ks_div_freq_in (ks_div_freq_in),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Model: outputs as a function of cycles since the accepting edge.
    logic [15:0] exp_noise;
    logic        exp_wr, exp_en, exp_pulse, exp_busy, exp_done, exp_err, exp_ready;
    logic [9:0]  exp_sel;
    logic [31:0] exp_div;
    logic [15:0] m_lfsr;
    logic [31:0] m_div;
    logic [1:0]  m_amp;
    bit          m_active;
    int          m_t, m_f, m_dur;

    task automatic model_apply();
        if (m_t < m_f) begin
            if (m_t % PER == 0) begin
                m_lfsr    = lfsr_next(m_lfsr);
                exp_noise = m_lfsr >> m_amp;
                exp_wr    = 1'b1;
                exp_pulse = 1'b0;
            end else begin
                exp_pulse = (m_t % PER) <= PH;
            end
        end else if (m_t == m_f) begin
            exp_pulse = 1'b0;
            exp_div   = m_div;
        end else if (m_t == m_f + 1) begin
            exp_en    = 1'b0;
            exp_ready = RETRIG;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            exp_noise = '0; exp_wr = 0; exp_en = 1; exp_pulse = 0; exp_sel = '0;
            exp_div = '0; exp_busy = 0; exp_done = 0; exp_err = 0; exp_ready = 1;
            m_lfsr = 16'hACE1; m_active = 0; m_t = 0; m_f = 0;
        end else begin
            exp_wr = 0; exp_done = 0; exp_err = 0;
            if (pif.req && exp_ready && pif.sel >= 10'd500) exp_err = 1'b1;
            if (pif.req && exp_ready && pif.sel < 10'd500) begin
                m_div = pif.div; m_amp = pif.amp; m_dur = int'(pif.dur);
                m_f = (int'(pif.sel) + 1) * PER; m_t = 0; m_active = 1;
                exp_sel = pif.sel; exp_busy = 1; exp_ready = 0; exp_en = 1;
                model_apply();
            end else if (m_active) begin
                if (m_t >= m_f + 1 && (stop || (m_dur != 0 && m_t == m_f + m_dur))) begin
                    m_active = 0; exp_en = 1; exp_done = 1; exp_busy = 0; exp_ready = 1;
                end else begin
                    m_t++;
                    model_apply();
                end
            end
        end
    end

    // Compare process and event monitor.
    int ncyc = 0;
    int wr_cnt, pulse_rise, pulse_hi_cyc, done_cnt, err_cnt;
    int first_wr_cyc, en_fall_cyc, en_rise_cyc, done_cyc;
    logic [15:0] first_noise, last_noise;
    bit top_bits_set, busy_seen, ready_in_play;
    logic prev_en = 1'b1, prev_pulse = 1'b0;

    task automatic clear_mon();
        wr_cnt = 0; pulse_rise = 0; pulse_hi_cyc = 0; done_cnt = 0; err_cnt = 0;
        first_wr_cyc = -1; en_fall_cyc = -1; en_rise_cyc = -1; done_cyc = -1;
        first_noise = '0; last_noise = '0;
        top_bits_set = 0; busy_seen = 0; ready_in_play = 0;
    endtask

    always @(negedge clk) begin
        ncyc++;
        check("outputs", 96'({ks_noise, ks_noise_wr, ks_noise_en, ks_noise_pulse, ks_sel_nota,
                             ks_div_freq_in, busy, done, err, pif.ready}),
                         96'({exp_noise, exp_wr, exp_en, exp_pulse, exp_sel,
                             exp_div, exp_busy, exp_done, exp_err, exp_ready}));
        if (ks_noise_wr) begin
            wr_cnt++;
            if (first_wr_cyc < 0) begin
                first_wr_cyc = ncyc;
                first_noise  = ks_noise;
            end
            last_noise = ks_noise;
            if (ks_noise[15:13] != 3'b000) top_bits_set = 1;
        end
        if (ks_noise_pulse) pulse_hi_cyc++;
        if (ks_noise_pulse && !prev_pulse) pulse_rise++;
        if (prev_en && !ks_noise_en) en_fall_cyc = ncyc;
        if (!prev_en && ks_noise_en) en_rise_cyc = ncyc;
        if (done) begin
            done_cnt++;
            done_cyc = ncyc;
        end
        if (err) err_cnt++;
        if (busy) busy_seen = 1;
        if (!ks_noise_en && pif.ready) ready_in_play = 1;
        prev_en    = ks_noise_en;
        prev_pulse = ks_noise_pulse;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_pluck(input logic [9:0] sel, input logic [31:0] div,
                            input logic [1:0] amp, input logic [23:0] dur);
        pif.sel = sel; pif.div = div; pif.amp = amp; pif.dur = dur; pif.req = 1'b1;
        for (int i = 0; i < 200 && !pif.ready; i++) tick();
        check("accept_ready", 96'(pif.ready), 96'(1));
        tick();
        pif.req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        check("idle_timeout", 96'(busy), 96'(0));
    endtask

    task automatic wait_en_low(input int budget);
        for (int i = 0; i < budget && ks_noise_en; i++) tick();
        check("play_timeout", 96'(ks_noise_en), 96'(0));
    endtask

    initial begin
        pif.req = 0; pif.sel = '0; pif.div = '0; pif.amp = '0; pif.dur = '0;
        clear_mon();
        repeat (3) tick();
        check("rst_state", 96'({ks_noise_en, pif.ready, busy, ks_noise, ks_noise_wr}),
                           96'({1'b1, 1'b1, 1'b0, 16'h0000, 1'b0}));
        reset = 1'b0;
        tick();

        // Basic pluck: 4 samples, 37-cycle fill latency, 50-cycle play.
        clear_mon();
        do_pluck(10'd3, 32'd100, 2'd0, 24'd50);
        wait_idle(300);
        tick();
        check("a_wr_count",   96'(wr_cnt), 96'(4));
        check("a_first",      96'(first_noise), 96'(16'hE270));
        check("a_last",       96'(last_noise), 96'(16'h1C4E));
        check("a_pulse_rise", 96'(pulse_rise), 96'(4));
        check("a_pulse_hi",   96'(pulse_hi_cyc), 96'(16));
        check("a_en_fall",    96'(en_fall_cyc - first_wr_cyc), 96'(37));
        check("a_play_len",   96'(en_rise_cyc - en_fall_cyc), 96'(50));
        check("a_done",       96'(done_cnt), 96'(1));
        check("a_div_sel",    96'({ks_div_freq_in, ks_sel_nota}), 96'({32'd100, 10'd3}));

        // Out-of-range tap is rejected.
        clear_mon();
        do_pluck(10'd500, 32'd7, 2'd0, 24'd9);
        repeat (5) tick();
        check("b_err",  96'(err_cnt), 96'(1));
        check("b_wr",   96'(wr_cnt), 96'(0));
        check("b_busy", 96'(busy_seen), 96'(0));
        check("b_sel",  96'(ks_sel_nota), 96'(3));

        // Attenuated noise.
        clear_mon();
        do_pluck(10'd2, 32'd33, 2'd3, 24'd5);
        wait_idle(200);
        check("c_top_bits", 96'(top_bits_set), 96'(0));
        check("c_first",    96'(first_noise), 96'(16'h01C4));
        check("c_wr",       96'(wr_cnt), 96'(3));

        // Endless play ended by stop; stop during the fill is ignored.
        clear_mon();
        do_pluck(10'd0, 32'd55, 2'd1, 24'd0);
        stop = 1'b1;
        repeat (3) tick();
        stop = 1'b0;
        wait_en_low(50);
        repeat (999) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (2) tick();
        check("d_wr",       96'(wr_cnt), 96'(1));
        check("d_done",     96'(done_cnt), 96'(1));
        check("d_same_cyc", 96'(done_cyc), 96'(en_rise_cyc));
        check("d_play_len", 96'(en_rise_cyc - en_fall_cyc), 96'(1000));

        // Reset mid-fill, then the LFSR restarts from its seed.
        clear_mon();
        do_pluck(10'd10, 32'd1, 2'd0, 24'd5);
        repeat (20) tick();
        reset = 1'b1;
        #1;
        check("e_rst_outs", 96'({ks_noise, ks_noise_wr, ks_noise_en, ks_noise_pulse,
                                ks_sel_nota, ks_div_freq_in, busy, done, err, pif.ready}),
                            96'({16'h0, 1'b0, 1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("e_no_done", 96'(done_cnt), 96'(0));
        clear_mon();
        do_pluck(10'd0, 32'd2, 2'd0, 24'd3);
        wait_idle(100);
        check("e_seed_restart", 96'(first_noise), 96'(16'hE270));

`ifdef KS_PLUCK_RETRIGGER_EN
        clear_mon();
        do_pluck(10'd2, 32'd40, 2'd0, 24'd0);
        wait_en_low(100);
        repeat (5) tick();
        check("f_ready_play", 96'(pif.ready), 96'(1));
        clear_mon();
        do_pluck(10'd1, 32'd41, 2'd0, 24'd0);
        wait_en_low(100);
        check("f_wr",   96'(wr_cnt), 96'(2));
        check("f_done", 96'(done_cnt), 96'(0));
        check("f_sel",  96'({ks_sel_nota, ks_div_freq_in}), 96'({10'd1, 32'd41}));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("f_stop_done", 96'(done_cnt), 96'(1));
`else
        clear_mon();
        do_pluck(10'd2, 32'd40, 2'd0, 24'd20);
        wait_idle(200);
        check("f_ready_play", 96'(ready_in_play), 96'(0));
        check("f_play_len",   96'(en_rise_cyc - en_fall_cyc), 96'(20));
        check("f_done",       96'(done_cnt), 96'(1));
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
